shift_pipe: RTL

- 16-bit pipelined barrel shifter for the execute path.
- One registered stage per shift-amount bit: shift by 1, 2, 4, then 8.
- A valid/ready handshake at both ends lets the execute stage stall it.
- Each stage is a conditional rotate/shift by a fixed power of two; the 2-bit stage is the second of the chain.

---
 rtl/shift_pipe_pkg.sv | 17 +
 rtl/shift_stage.sv | 30 +++
 rtl/shift_pipe.sv | 114 +++++++++++
 3 files changed

// File: rtl/shift_pipe_pkg.sv
// Shared definitions for the shift_pipe barrel shifter.
//   WIDTH : default datapath width (power of two)
//   SHW   : shift-amount width, which is also the pipeline depth
//   op_e  : operation encodings carried alongside each operand
package shift_pipe_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SHW   = $clog2(WIDTH);

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,  // rotate left
    OP_SLL = 2'b01,  // shift left logical
    OP_ROR = 2'b10,  // rotate right
    OP_SRL = 2'b11   // shift right logical
  } op_e;

endpackage

// File: rtl/shift_stage.sv
// Combinational conditional shift by a fixed distance.
//   en     : apply the shift when high, otherwise pass data_i through
//   oper   : rotate/shift direction and fill mode
//   data_i : operand
//   data_o : result
module shift_stage #(
  parameter int unsigned WIDTH = shift_pipe_pkg::WIDTH,
  parameter int unsigned DIST  = 1
) (
  input  logic                  en,
  input  shift_pipe_pkg::op_e   oper,
  input  logic [WIDTH-1:0]      data_i,
  output logic [WIDTH-1:0]      data_o
);
  import shift_pipe_pkg::*;

  always_comb begin
    data_o = data_i;
    if (en) begin
      case (oper)
        OP_ROL: data_o = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
        OP_SLL: data_o = data_i << DIST;
        OP_ROR: data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
        OP_SRL: data_o = data_i >> DIST;
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit
// (shift by 1, 2, 4, ... in order), with a valid/ready handshake at both ends.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : input handshake; in_ready is stage 0's ready
//   in_data             : operand
//   in_shamt            : shift amount 0..WIDTH-1
//   in_oper             : 00 rol, 01 sll, 10 ror, 11 srl
//   out_valid/out_ready : output handshake
//   out_data            : shifted result, held stable while stalled
module shift_pipe #(
  parameter  int unsigned WIDTH = shift_pipe_pkg::WIDTH,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SHW-1:0]    in_shamt,
  input  logic [1:0]        in_oper,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data
);
  import shift_pipe_pkg::*;

  logic [SHW:0]                ready;
  logic [SHW-1:0]              valid_q, valid_d, src_valid, stage_en;
  logic [SHW-1:0][WIDTH-1:0]   data_q, data_d, src_data, shifted;
  logic [SHW-1:0][SHW-1:0]     shamt_q, shamt_d, src_shamt;
  op_e  [SHW-1:0]              oper_q, oper_d, src_oper;

  // Inputs to each stage: stage 0 from the ports, stage k from stage k-1.
  always_comb begin
    src_valid    = '0;
    src_data     = '0;
    src_shamt    = '0;
    src_oper     = {SHW{OP_ROL}};
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_oper[0]  = op_e'(in_oper);
    for (int unsigned k = 1; k < SHW; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_oper[k]  = oper_q[k-1];
    end
    for (int unsigned k = 0; k < SHW; k++) begin
      stage_en[k] = src_shamt[k][k];
    end
  end

  for (genvar g = 0; g < SHW; g++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << g)
    ) u_stage (
      .en     (stage_en[g]),
      .oper   (src_oper[g]),
      .data_i (src_data[g]),
      .data_o (shifted[g])
    );
  end

  // Ready ripples back from the consumer; an empty stage is always ready,
  // which is what lets bubbles collapse while the output is stalled.
  always_comb begin
    ready      = '0;
    ready[SHW] = out_ready;
    for (int unsigned i = 0; i < SHW; i++) begin
      ready[SHW-1-i] = ~valid_q[SHW-1-i] | ready[SHW-i];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    oper_d  = oper_q;
    for (int unsigned k = 0; k < SHW; k++) begin
      if (ready[k]) begin
        valid_d[k] = src_valid[k];
        data_d[k]  = shifted[k];
        shamt_d[k] = src_shamt[k];
        oper_d[k]  = src_oper[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload registers carry no reset; their content is qualified by valid_q.
  always_ff @(posedge clk) begin
    data_q  <= data_d;
    shamt_q <= shamt_d;
    oper_q  <= oper_d;
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];

  // The last stage's shamt/oper travel with the data but feed nothing further.
  logic unused_tail;
  assign unused_tail = ^{shamt_q[SHW-1], oper_q[SHW-1]};

endmodule
